// File: rtl/uart_tx.sv
// UART transmit serializer on the 16x baud clock: start bit, n data bits LSB
// first, optional parity, one or two stop bits. Frame format is latched at acceptance.
module uart_tx #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk_16bd,
   input  logic       rst_n,
   input  logic [8:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       parity,
   input  logic       parity_type,
   input  logic       stop_bits,
   input  logic [3:0] frame_length,
   output logic       tx,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

   state_t     state, state_nxt;
   logic [3:0] tick, tick_nxt;
   logic [3:0] bit_idx, bit_idx_nxt;
   logic [8:0] data_q;
   logic [3:0] len_q;
   logic       par_en_q;
   logic       par_bit_q;
   logic       two_stop_q;

   logic       accept;
   logic       tx_nxt;
   logic [3:0] n_eff;
   logic [8:0] data_mask;
   logic       par_calc;

   // Valid/ready: a word moves when tx_valid and tx_ready are both high at a
   // rising edge; tx_ready is registered and high only while IDLE.
   assign accept = tx_valid && tx_ready;

   always_comb begin
      n_eff = frame_length;
      if (frame_length < 4'd5) begin
         n_eff = 4'd5;
      end else if (frame_length > 4'd9) begin
         n_eff = 4'd9;
      end
      data_mask = 9'h1FF >> (4'd9 - n_eff);
      par_calc  = (^(tx_data & data_mask)) ^ parity_type;
   end

   always_comb begin
      state_nxt   = state;
      tick_nxt    = tick;
      bit_idx_nxt = bit_idx;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt   = START;
               tick_nxt    = 4'd0;
               bit_idx_nxt = 4'd0;
            end
         end
         START: begin
            tick_nxt = tick + 4'd1;
            if (tick == LAST_TICK) begin
               state_nxt   = DATA;
               bit_idx_nxt = 4'd0;
            end
         end
         DATA: begin
            tick_nxt = tick + 4'd1;
            if (tick == LAST_TICK) begin
               if (bit_idx == len_q - 4'd1) begin
                  state_nxt   = par_en_q ? PARITY : STOP;
                  bit_idx_nxt = 4'd0;
               end else begin
                  bit_idx_nxt = bit_idx + 4'd1;
               end
            end
         end
         PARITY: begin
            tick_nxt = tick + 4'd1;
            if (tick == LAST_TICK) begin
               state_nxt   = STOP;
               bit_idx_nxt = 4'd0;
            end
         end
         STOP: begin
            tick_nxt = tick + 4'd1;
            // bit_idx counts stop bits so two-stop frames reuse the same state
            if (tick == LAST_TICK) begin
               if (two_stop_q && bit_idx == 4'd0) begin
                  bit_idx_nxt = 4'd1;
               end else begin
                  state_nxt   = IDLE;
                  bit_idx_nxt = 4'd0;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Line level is derived from the next state so tx is registered yet aligned
   // with the state it belongs to.
   always_comb begin
      tx_nxt = 1'b1;
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = data_q[bit_idx_nxt];
         PARITY:  tx_nxt = par_bit_q;
         default: tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk_16bd or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tick       <= 4'd0;
         bit_idx    <= 4'd0;
         data_q     <= 9'd0;
         len_q      <= 4'd0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         two_stop_q <= 1'b0;
         tx         <= 1'b1;
         tx_ready   <= 1'b1;
         busy       <= 1'b0;
      end else begin
         state    <= state_nxt;
         tick     <= tick_nxt;
         bit_idx  <= bit_idx_nxt;
         tx       <= tx_nxt;
         tx_ready <= (state_nxt == IDLE);
         busy     <= (state_nxt != IDLE);
         if (accept) begin
            data_q     <= tx_data & data_mask;
            len_q      <= n_eff;
            par_en_q   <= parity;
            par_bit_q  <= par_calc;
            two_stop_q <= stop_bits;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of frames with hand-computed line patterns,
// plus back-to-back and mid-frame reset sequences.
module tb_uart_tx;

   logic       clk_16bd;
   logic       rst_n;
   logic [8:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       parity;
   logic       parity_type;
   logic       stop_bits;
   logic [3:0] frame_length;
   logic       tx;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;

   uart_tx #(.OVERSAMPLE(16)) dut (
      .clk_16bd     (clk_16bd),
      .rst_n        (rst_n),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .parity       (parity),
      .parity_type  (parity_type),
      .stop_bits    (stop_bits),
      .frame_length (frame_length),
      .tx           (tx),
      .busy         (busy)
   );

   initial clk_16bd = 1'b0;
   always #5 clk_16bd = ~clk_16bd;

   // line: bits in transmission order, first bit at [12], padded with idle 1s
   typedef struct {
      logic [8:0]  data;
      logic [3:0]  flen;
      logic        par;
      logic        ptype;
      logic        stop;
      int          nbits;
      logic [12:0] line;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Present a word and return #1 after the edge that accepts it.
   task automatic send(input logic [8:0] d, input logic [3:0] fl, input logic p,
                       input logic pt, input logic st, input logic hold_valid);
      bit done = 0;
      @(negedge clk_16bd);
      tx_data = d; frame_length = fl; parity = p; parity_type = pt; stop_bits = st;
      tx_valid = 1'b1;
      for (int i = 0; i < 1000 && !done; i++) begin
         if (tx_ready) done = 1;
         @(posedge clk_16bd);
         if (!done) @(negedge clk_16bd);
      end
      #1;
      if (!hold_valid) tx_valid = 1'b0;
      if (!done) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   // Starts #1 after the acceptance edge; checks every cycle of the frame and
   // the idle cycle that follows, returning at that idle cycle's negedge.
   task automatic check_frame(input logic [12:0] line, input int nbits, input logic scramble);
      for (int c = 0; c < nbits * 16; c++) begin
         @(negedge clk_16bd);
         if (scramble && c == 20) begin
            frame_length = ~frame_length;
            parity       = ~parity;
            parity_type  = ~parity_type;
            stop_bits    = ~stop_bits;
            tx_data      = 9'($urandom_range(0, 511));
         end
         chk("tx_bit", 32'(tx), 32'(line[12 - (c / 16)]));
         chk("ready_low", 32'(tx_ready), 32'd0);
         chk("busy_high", 32'(busy), 32'd1);
         @(posedge clk_16bd);
      end
      @(negedge clk_16bd);
      chk("end_tx", 32'(tx), 32'd1);
      chk("end_ready", 32'(tx_ready), 32'd1);
      chk("end_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      vecs[0] = '{9'h055, 4'd8,  1'b1, 1'b0, 1'b0, 11, 13'b0101010100111};
      vecs[1] = '{9'h041, 4'd7,  1'b1, 1'b1, 1'b0, 10, 13'b0100000111111};
      vecs[2] = '{9'h01F, 4'd5,  1'b0, 1'b0, 1'b1,  8, 13'b0111111111111};
      vecs[3] = '{9'h1E0, 4'd5,  1'b1, 1'b0, 1'b0,  8, 13'b0000000111111};
      vecs[4] = '{9'h013, 4'd0,  1'b1, 1'b1, 1'b0,  8, 13'b0110010111111};
      vecs[5] = '{9'h1AA, 4'd15, 1'b0, 1'b0, 1'b0, 11, 13'b0010101011111};
      vecs[6] = '{9'h0FF, 4'd12, 1'b1, 1'b0, 1'b1, 13, 13'b0111111110011};
      vecs[7] = '{9'h1EA, 4'd4,  1'b1, 1'b1, 1'b1,  9, 13'b0010101111111};

      rst_n = 1'b0; tx_valid = 1'b0; tx_data = 9'd0;
      parity = 1'b1; parity_type = 1'b0; stop_bits = 1'b0; frame_length = 4'd8;
      repeat (3) @(posedge clk_16bd);
      @(negedge clk_16bd);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_ready", 32'(tx_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;

      for (int v = 0; v < 8; v++) begin
         send(vecs[v].data, vecs[v].flen, vecs[v].par, vecs[v].ptype, vecs[v].stop, 1'b0);
         check_frame(vecs[v].line, vecs[v].nbits, 1'b1);
      end

      // Back-to-back: valid stays high, second word must follow after one idle cycle.
      send(9'h055, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1);
      tx_data = 9'h041; frame_length = 4'd7; parity_type = 1'b1;
      check_frame(13'b0101010100111, 11, 1'b0);
      @(posedge clk_16bd);
      #1;
      tx_valid = 1'b0;
      check_frame(13'b0100000111111, 10, 1'b0);
      repeat (40) begin
         @(negedge clk_16bd);
         chk("no_dup_ready", 32'(tx_ready), 32'd1);
      end

      // Reset in the middle of the data bits.
      send(9'h055, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (40) @(posedge clk_16bd);
      @(negedge clk_16bd);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tx", 32'(tx), 32'd1);
      chk("mid_rst_ready", 32'(tx_ready), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk_16bd);
      rst_n = 1'b1;
      send(9'h041, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
      check_frame(13'b0100000111111, 10, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
